// File: rtl/hier_tree_node.sv
// hier_tree_node: NUM_CHILD-way interior node of the module tree.
// Routes requests by child index and merges responses round-robin.
module hier_tree_node #(
  parameter int NUM_CHILD = 5,
  parameter int DATA_W = 32,
  parameter int MAX_OUTST = 4,
  localparam int IDX_W = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic up_req_valid,
  output logic up_req_ready,
  input  logic [IDX_W-1:0] up_req_idx,
  input  logic [DATA_W-1:0] up_req_data,
  output logic up_rsp_valid,
  input  logic up_rsp_ready,
  output logic [IDX_W-1:0] up_rsp_idx,
  output logic [DATA_W-1:0] up_rsp_data,
  output logic up_rsp_err,
  output logic [NUM_CHILD-1:0] dn_req_valid,
  input  logic [NUM_CHILD-1:0] dn_req_ready,
  output logic [NUM_CHILD*DATA_W-1:0] dn_req_data,
  input  logic [NUM_CHILD-1:0] dn_rsp_valid,
  output logic [NUM_CHILD-1:0] dn_rsp_ready,
  input  logic [NUM_CHILD*DATA_W-1:0] dn_rsp_data,
  output logic busy
);
  localparam int NS = NUM_CHILD + 1;
  localparam int PW = $clog2(NS);
  localparam int CW = $clog2(MAX_OUTST + 1);

  typedef enum logic { REQ_EMPTY, REQ_FULL } req_state_t;

  req_state_t req_state;
  req_state_t req_state_nxt;
  logic [IDX_W-1:0] req_idx;
  logic [DATA_W-1:0] req_data;
  logic [CW-1:0] cnt [NUM_CHILD];
  logic [PW-1:0] ptr;
  logic rsp_full;
  logic [IDX_W-1:0] rsp_idx;
  logic [DATA_W-1:0] rsp_data;
  logic rsp_err;

  logic req_full;
  logic head_ok;
  logic req_bad;
  logic dispatch;
  logic req_done;
  logic [NS-1:0] rsp_req;
  logic [2*NS-1:0] rot2;
  logic found;
  logic grant_any;
  logic [PW-1:0] grant_idx;
  logic [IDX_W-1:0] sel_idx;
  logic [DATA_W-1:0] sel_data;
  logic sel_err;
  logic [NUM_CHILD-1:0] inc;
  logic [NUM_CHILD-1:0] dec;

  function automatic logic [PW-1:0] wrap(input int v);
    return PW'((v >= NS) ? v - NS : v);
  endfunction

  assign req_full = (req_state == REQ_FULL);
  assign dn_req_data = {NUM_CHILD{req_data}};

  always_comb begin
    head_ok = 1'b0;
    for (int i = 0; i < NUM_CHILD; i++) begin
      if (int'(req_idx) == i) head_ok = int'(cnt[i]) < MAX_OUTST;
    end
    req_bad = req_full && (int'(req_idx) >= NUM_CHILD);
    dn_req_valid = '0;
    for (int i = 0; i < NUM_CHILD; i++) begin
      dn_req_valid[i] = req_full && head_ok && (int'(req_idx) == i);
    end
  end

  assign dispatch = |(dn_req_valid & dn_req_ready);
  assign req_done = dispatch ||
    (req_bad && grant_any && (int'(grant_idx) == NUM_CHILD));

  always_comb begin
    req_state_nxt = req_state;
    up_req_ready = 1'b0;
    unique case (req_state)
      REQ_EMPTY: begin
        up_req_ready = 1'b1;
        if (up_req_valid) req_state_nxt = REQ_FULL;
      end
      REQ_FULL: begin
        up_req_ready = req_done;
        if (req_done && !up_req_valid) req_state_nxt = REQ_EMPTY;
      end
    endcase
  end

  // Slot NUM_CHILD is the local error response for a bad index.
  assign rsp_req = {req_bad, dn_rsp_valid};
  assign rot2 = {rsp_req, rsp_req} >> ptr;

  always_comb begin
    found = 1'b0;
    grant_idx = '0;
    for (int j = 0; j < NS; j++) begin
      if (!found && rot2[j]) begin
        found = 1'b1;
        grant_idx = wrap(int'(ptr) + j);
      end
    end
  end

  assign grant_any = found && (!rsp_full || up_rsp_ready);

  always_comb begin
    dn_rsp_ready = '0;
    sel_idx = req_idx;
    sel_data = '0;
    sel_err = 1'b1;
    for (int i = 0; i < NUM_CHILD; i++) begin
      if (int'(grant_idx) == i) begin
        dn_rsp_ready[i] = grant_any;
        sel_idx = IDX_W'(i);
        sel_data = dn_rsp_data[i*DATA_W +: DATA_W];
        sel_err = (cnt[i] == '0);
      end
    end
  end

  always_comb begin
    busy = req_full || rsp_full;
    for (int i = 0; i < NUM_CHILD; i++) begin
      inc[i] = dn_req_valid[i] && dn_req_ready[i];
      dec[i] = dn_rsp_valid[i] && dn_rsp_ready[i] && (cnt[i] != '0);
      if (cnt[i] != '0) busy = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_state <= REQ_EMPTY;
      req_idx <= '0;
      req_data <= '0;
    end else begin
      req_state <= req_state_nxt;
      if (up_req_valid && up_req_ready) begin
        req_idx <= up_req_idx;
        req_data <= up_req_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_full <= 1'b0;
      rsp_idx <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      ptr <= '0;
    end else if (grant_any) begin
      rsp_full <= 1'b1;
      rsp_idx <= sel_idx;
      rsp_data <= sel_data;
      rsp_err <= sel_err;
      ptr <= wrap(int'(grant_idx) + 1);
    end else if (up_rsp_ready) begin
      rsp_full <= 1'b0;
    end
  end

  // Unsolicited responses never decrement, so counters cannot underflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHILD; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CHILD; i++) begin
        if (inc[i] && !dec[i]) cnt[i] <= cnt[i] + CW'(1);
        else if (dec[i] && !inc[i]) cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

  assign up_rsp_valid = rsp_full;
  assign up_rsp_idx = rsp_idx;
  assign up_rsp_data = rsp_data;
  assign up_rsp_err = rsp_err;

endmodule

// File: tb/tb_hier_tree_node.sv
// Bench for hier_tree_node: directed and random traffic
// against a transaction-level model of children and upstream.
module tb_hier_tree_node;
  localparam int NC = 5;
  localparam int DW = 32;
  localparam int IW = 3;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst;
  logic up_req_valid;
  logic up_req_ready;
  logic [IW-1:0] up_req_idx;
  logic [DW-1:0] up_req_data;
  logic up_rsp_valid;
  logic up_rsp_ready;
  logic [IW-1:0] up_rsp_idx;
  logic [DW-1:0] up_rsp_data;
  logic up_rsp_err;
  logic [NC-1:0] dn_req_valid;
  logic [NC-1:0] dn_req_ready;
  logic [NC*DW-1:0] dn_req_data;
  logic [NC-1:0] dn_rsp_valid;
  logic [NC-1:0] dn_rsp_ready;
  logic [NC*DW-1:0] dn_rsp_data;
  logic busy;

  hier_tree_node #(.NUM_CHILD(NC), .DATA_W(DW), .MAX_OUTST(MO)) dut (
    .clk(clk), .rst(rst),
    .up_req_valid(up_req_valid), .up_req_ready(up_req_ready),
    .up_req_idx(up_req_idx), .up_req_data(up_req_data),
    .up_rsp_valid(up_rsp_valid), .up_rsp_ready(up_rsp_ready),
    .up_rsp_idx(up_rsp_idx), .up_rsp_data(up_rsp_data),
    .up_rsp_err(up_rsp_err),
    .dn_req_valid(dn_req_valid), .dn_req_ready(dn_req_ready),
    .dn_req_data(dn_req_data),
    .dn_rsp_valid(dn_rsp_valid), .dn_rsp_ready(dn_rsp_ready),
    .dn_rsp_data(dn_rsp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [IW-1:0] idx; logic [DW-1:0] data; } req_t;
  typedef struct packed { logic [DW-1:0] data; logic err; } rsp_t;
  typedef struct packed { logic [DW-1:0] data; int due; } pend_t;

  req_t send_q[$];
  req_t disp_q[$];
  logic [IW-1:0] bad_q[$];
  rsp_t exp_q[NC][$];
  pend_t chq[NC][$];
  int outst[NC];
  int budget[NC];
  int disp_n[NC];
  int crsp_n[NC];
  int rsp_n, cyc, delay, rdy_pct, urdy_pct, rr_n;
  bit rr_mode, req_fired;
  bit [NC-1:0] rsp_fired;
  int npass = 0;
  int ntot = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int pending();
    int s;
    s = send_q.size() + disp_q.size() + bad_q.size();
    for (int i = 0; i < NC; i++) s += exp_q[i].size();
    return s;
  endfunction

  task automatic observe();
    req_t h;
    rsp_t e;
    logic [IW-1:0] b;
    if (disp_q.size() == 0) chk("idle_no_dn_valid", dn_req_valid, 0);
    for (int i = 0; i < NC; i++) begin
      if (outst[i] >= MO) chk("limit_holds_valid", dn_req_valid[i], 0);
      if (dn_req_valid[i] && dn_req_ready[i]) begin
        if (disp_q.size() > 0) begin
          h = disp_q.pop_front();
          chk("dispatch_idx", i, h.idx);
          chk("dispatch_data", dn_req_data[i*DW +: DW], h.data);
          exp_q[i].push_back('{data: h.data + 1, err: 1'b0});
        end
        chq[i].push_back('{data: dn_req_data[i*DW +: DW] + 1, due: cyc + delay});
        outst[i]++;
        disp_n[i]++;
      end
      if (dn_rsp_valid[i] && dn_rsp_ready[i]) begin
        rsp_fired[i] = 1'b1;
        crsp_n[i]++;
        if (chq[i].size() > 0) void'(chq[i].pop_front());
        if (budget[i] > 0) budget[i]--;
        if (outst[i] > 0) outst[i]--;
      end
    end
    if (up_rsp_valid && up_rsp_ready) begin
      rsp_n++;
      if (rr_mode) begin
        chk("rr_order", up_rsp_idx, rr_n % NC);
        rr_n++;
      end
      if (int'(up_rsp_idx) < NC) begin
        chk("rsp_pending", exp_q[up_rsp_idx].size() > 0, 1);
        if (exp_q[up_rsp_idx].size() > 0) begin
          e = exp_q[up_rsp_idx].pop_front();
          chk("rsp_data", up_rsp_data, e.data);
          chk("rsp_err", up_rsp_err, e.err);
        end
      end else begin
        chk("err_pending", bad_q.size() > 0, 1);
        if (bad_q.size() > 0) begin
          b = bad_q.pop_front();
          chk("err_idx", up_rsp_idx, b);
          chk("err_data", up_rsp_data, 0);
          chk("err_flag", up_rsp_err, 1);
        end
      end
    end
    if (up_req_valid && up_req_ready) begin
      req_fired = 1'b1;
      h = send_q.pop_front();
      if (int'(h.idx) < NC) disp_q.push_back(h);
      else bad_q.push_back(h.idx);
    end
  endtask

  task automatic drive();
    if (!up_req_valid || req_fired) begin
      up_req_valid = send_q.size() > 0;
      if (send_q.size() > 0) begin
        up_req_idx = send_q[0].idx;
        up_req_data = send_q[0].data;
      end
    end
    for (int i = 0; i < NC; i++) begin
      if (!dn_rsp_valid[i] || rsp_fired[i]) begin
        dn_rsp_valid[i] = chq[i].size() > 0 && chq[i][0].due <= cyc &&
                          budget[i] != 0;
        if (dn_rsp_valid[i]) dn_rsp_data[i*DW +: DW] = chq[i][0].data;
      end
      dn_req_ready[i] = int'($urandom_range(99)) < rdy_pct;
    end
    up_rsp_ready = int'($urandom_range(99)) < urdy_pct;
    req_fired = 1'b0;
    rsp_fired = '0;
  endtask

  task automatic cycle();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    send_q.delete();
    disp_q.delete();
    bad_q.delete();
    for (int i = 0; i < NC; i++) begin
      exp_q[i].delete();
      chq[i].delete();
      outst[i] = 0;
      budget[i] = -1;
      disp_n[i] = 0;
      crsp_n[i] = 0;
    end
    up_req_valid = 1'b0;
    up_req_idx = '0;
    up_req_data = '0;
    up_rsp_ready = 1'b0;
    dn_req_ready = '0;
    dn_rsp_valid = '0;
    dn_rsp_data = '0;
    req_fired = 1'b0;
    rsp_fired = '0;
    rsp_n = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    rst = 1'b0;
  endtask

  task automatic drain(int maxc);
    int n;
    n = 0;
    while ((pending() != 0 || busy) && n < maxc) begin
      cycle();
      n++;
    end
    chk("drain_done", (pending() << 1) | int'(busy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, sent, ri;
    cyc = 0;
    delay = 3;
    rdy_pct = 100;
    urdy_pct = 100;
    rr_mode = 1'b0;
    rr_n = 0;
    do_reset(2);
    chk("rst_up_req_ready", up_req_ready, 1);
    chk("rst_up_rsp_valid", up_rsp_valid, 0);
    chk("rst_up_rsp_idx", up_rsp_idx, 0);
    chk("rst_up_rsp_data", up_rsp_data, 0);
    chk("rst_up_rsp_err", up_rsp_err, 0);
    chk("rst_dn_req_valid", dn_req_valid, 0);
    chk("rst_dn_rsp_ready", dn_rsp_ready, 0);
    chk("rst_busy", busy, 0);
    repeat (3) cycle();
    chk("idle_busy", busy, 0);
    chk("idle_ready", up_req_ready, 1);

    for (int i = 0; i < NC; i++) send_q.push_back('{IW'(i), DW'(32'h100 + i)});
    drain(200);
    chk("route_rsp_count", rsp_n, NC);
    for (int i = 0; i < NC; i++) chk("route_disp", disp_n[i], 1);

    for (int i = 0; i < NC; i++) begin
      disp_n[i] = 0;
      crsp_n[i] = 0;
    end
    budget[2] = 0;
    for (int k = 0; k < 6; k++) send_q.push_back('{IW'(2), DW'(32'h200 + k)});
    repeat (20) cycle();
    chk("limit_disp", disp_n[2], MO);
    chk("limit_valid", dn_req_valid[2], 0);
    chk("limit_up_ready", up_req_ready, 0);
    chk("limit_busy", busy, 1);
    budget[2] = 1;
    n = 0;
    while (crsp_n[2] == 0 && n < 20) begin
      cycle();
      n++;
    end
    chk("limit_one_rsp", crsp_n[2], 1);
    cycle();
    chk("limit_redispatch", disp_n[2], MO + 1);
    budget[2] = -1;
    drain(300);

    do_reset(1);
    for (int i = 0; i < NC; i++) budget[i] = 0;
    for (int k = 0; k < MO; k++)
      for (int i = 0; i < NC; i++)
        send_q.push_back('{IW'(i), DW'(32'h300 + k * 16 + i)});
    repeat (40) cycle();
    n = 0;
    for (int i = 0; i < NC; i++) n += disp_n[i];
    chk("rr_preload", n, NC * MO);
    rr_mode = 1'b1;
    rr_n = 0;
    for (int i = 0; i < NC; i++) budget[i] = -1;
    drain(200);
    chk("rr_count", rr_n, NC * MO);
    rr_mode = 1'b0;

    base = rsp_n;
    send_q.push_back('{IW'(7), DW'(32'hABCD)});
    send_q.push_back('{IW'(5), DW'(32'h1234)});
    drain(50);
    chk("err_count", rsp_n - base, 2);
    chq[3].push_back('{data: DW'(32'hDEAD0003), due: cyc});
    exp_q[3].push_back('{data: DW'(32'hDEAD0003), err: 1'b1});
    drain(50);
    repeat (2) cycle();
    chk("unsol_cnt_zero", busy, 0);
    send_q.push_back('{IW'(3), DW'(32'h333)});
    drain(50);

    do_reset(1);
    delay = 1;
    urdy_pct = 0;
    send_q.push_back('{IW'(0), DW'(32'h400)});
    send_q.push_back('{IW'(1), DW'(32'h410)});
    n = 0;
    while (!up_rsp_valid && n < 20) begin
      cycle();
      n++;
    end
    chk("bp_valid", up_rsp_valid, 1);
    repeat (10) begin
      cycle();
      chk("bp_hold_valid", up_rsp_valid, 1);
      chk("bp_hold_idx", up_rsp_idx, 0);
      chk("bp_hold_data", up_rsp_data, 32'h401);
      chk("bp_hold_err", up_rsp_err, 0);
      chk("bp_no_grant", dn_rsp_ready, 0);
    end
    urdy_pct = 100;
    drain(50);

    budget[4] = 0;
    send_q.push_back('{IW'(4), DW'(32'h500)});
    repeat (6) cycle();
    chk("rst_busy_before", busy, 1);
    do_reset(1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", up_req_ready, 1);
    chk("rst_mid_rsp_valid", up_rsp_valid, 0);
    chk("rst_mid_dn_valid", dn_req_valid, 0);
    repeat (3) cycle();
    chk("rst_mid_counters", busy, 0);

    do_reset(2);
    rdy_pct = 70;
    urdy_pct = 70;
    sent = 0;
    for (int t = 0; t < 500; t++) begin
      if (send_q.size() < 2 && $urandom_range(3) != 0) begin
        ri = ($urandom_range(15) == 0) ? 5 + int'($urandom_range(2))
                                       : int'($urandom_range(4));
        send_q.push_back('{IW'(ri), DW'($urandom())});
        sent++;
      end
      delay = int'($urandom_range(5));
      cycle();
    end
    drain(2000);
    chk("rand_rsp_count", rsp_n, sent);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/hier_tree_node.md
# hier_tree_node

Parametrised interior node of the generated module hierarchy. It replaces the fixed five-child, port-less wrapper with a live NUM_CHILD-way node. The node routes upstream requests to one child by index, tracks outstanding transactions per child, and merges child responses upstream through a round-robin arbiter. Nodes cascade: a node's upstream port connects to a parent node's child port, so one block builds trees of any fan-out and depth.

## Interface
Parameters:
- NUM_CHILD, 5, number of child ports (2..16)
- DATA_W, 32, payload width
- IDX_W, $clog2(NUM_CHILD) (min 1), child index width; derived, not overridden
- MAX_OUTST, 4, maximum outstanding requests per child (1..15)

Ports:
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- up_req_valid  in  1  upstream request valid
- up_req_ready  out  1  upstream request ready
- up_req_idx  in  IDX_W  target child index
- up_req_data  in  DATA_W  request payload
- up_rsp_valid  out  1  upstream response valid
- up_rsp_ready  in  1  upstream response ready
- up_rsp_idx  out  IDX_W  child that produced the response
- up_rsp_data  out  DATA_W  response payload
- up_rsp_err  out  1  bad index or unexpected response
- dn_req_valid  out  NUM_CHILD  per-child request valid
- dn_req_ready  in  NUM_CHILD  per-child request ready
- dn_req_data  out  NUM_CHILD*DATA_W  per-child payload; child i at [i*DATA_W +: DATA_W]
- dn_rsp_valid  in  NUM_CHILD  per-child response valid
- dn_rsp_ready  out  NUM_CHILD  per-child response ready
- dn_rsp_data  in  NUM_CHILD*DATA_W  per-child response payload, same packing
- busy  out  1  any outstanding counter nonzero, or any register stage occupied

## Operation
- Handshakes: a transfer occurs on a cycle with valid && ready. Valid, once high, holds with stable payload until the transfer.
- Request stage: one-entry register, REQ_EMPTY/REQ_FULL.
  - up_req_ready = REQ_EMPTY, or the held request completes this cycle.
  - REQ_FULL with idx < NUM_CHILD and cnt[idx] < MAX_OUTST drives dn_req_valid[idx]. Dispatch on dn_req_ready[idx]: cnt[idx]++.
  - cnt[idx] == MAX_OUTST: request holds and dn_req_valid stays low (head-of-line stall).
  - idx >= NUM_CHILD: no child is driven. The request raises a local error response (data 0, err 1, idx echoed) into arbiter slot NUM_CHILD and completes when that slot wins.
- Response arbiter: NUM_CHILD+1 requesters (children 0..NUM_CHILD-1, then the local error slot). Round-robin, pointer starts at 0.
  - After a grant to slot k, the next search starts at k+1 mod (NUM_CHILD+1).
  - Grant is issued only when the response register is empty or draining this cycle. dn_rsp_ready[k] is high only for the granted child.
- Counters: cnt[i] decrements on a dn_rsp transfer from child i. Dispatch and response on the same child in one cycle leave cnt unchanged.
- A response from child i while cnt[i] == 0 is forwarded with err = 1; cnt stays 0 (no underflow).
- Response register: one entry holding idx/data/err. up_rsp_valid stays high until up_rsp_ready.

## Timing
- Reset values: up_req_ready 1, up_rsp_valid 0, up_rsp_idx/data/err 0, dn_req_valid 0, dn_rsp_ready 0, busy 0. All cnt cleared, arbiter pointer 0, both stages empty.
- rst mid-operation: in-flight request and response are dropped and counters cleared. Children are expected to be reset by the same rst.
- Request latency: upstream accept at cycle t gives dn_req_valid at t+1 (if not stalled).
- Response latency: child transfer at cycle t gives up_rsp_valid at t+1.
- Bad index: accept at t, error response visible at t+2 (one arbiter cycle) if no other requester wins.
- Throughput: one request and one response per cycle when unstalled. Back-to-back transfers are allowed on both stages.
- Simultaneous upstream accept and dispatch of the held request in one cycle: the new request is captured with no bubble.

## Test plan
- Reset then idle: assert rst 2 cycles -> all outputs at reset values, busy 0, up_req_ready 1.
- Routing: NUM_CHILD=5, send idx 0..4 with data 0x100+idx, children always ready and echoing data+1 after 3 cycles -> each dn_req_data slice correct; up_rsp returns idx i with data 0x101+i, err 0.
- Outstanding limit: MAX_OUTST=4, child 2 never responds, send 6 requests to idx 2 -> 4 dispatched, 5th held with dn_req_valid[2]=0 and up_req_ready=0. One response from child 2 -> 5th dispatches next cycle.
- Round-robin fairness: all 5 children present responses continuously, up_rsp_ready=1 -> up_rsp_idx sequence 0,1,2,3,4,0,... with no slot granted twice before the others.
- Errors: idx=7 -> up_rsp err 1, data 0, idx 7, no dn_req_valid asserted. Unsolicited response from child 3 with cnt[3]=0 -> forwarded with err 1, cnt[3] stays 0.
- Backpressure and reset: up_rsp_ready low 10 cycles with pending child responses -> up_rsp payload stable, dn_rsp_ready all 0. Assert rst while busy -> next cycle busy 0, counters 0.
